// File: rtl/reset_sequencer_if.sv
// Hold-reset input, per-domain request pulses and the sequencer's reset/status outputs.
// master is the control/generator side, slave is the sequencer.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_BITS    = 16
);
  logic                   hold_reset_i;
  logic [NUM_DOMAINS-1:0] domain_reset_req_i;
  logic [NUM_DOMAINS-1:0] domain_reset_o;
  logic                   sequence_done_o;
  logic [CNT_BITS-1:0]    hold_reset_count_o;

  modport master (
    output hold_reset_i,
    output domain_reset_req_i,
    input  domain_reset_o,
    input  sequence_done_o,
    input  hold_reset_count_o
  );

  modport slave (
    input  hold_reset_i,
    input  domain_reset_req_i,
    output domain_reset_o,
    output sequence_done_o,
    output hold_reset_count_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staggered per-domain reset release after the hold reset, then stretched per-domain resets on request.
// All outputs registered; hold_reset_i aborts and restarts the sequence; rising hold edges are counted (saturating).
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int STAGGER_CYCLES = 64,
  parameter int PULSE_CYCLES   = 32,
  parameter int CNT_BITS       = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  reset_sequencer_if.slave bus
);

  localparam int CW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int SW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(STAGGER_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

  typedef enum logic [1:0] {HOLD, STAGE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          pulse_q [NUM_DOMAINS];
  logic [PW-1:0]          pulse_d [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic                   hold_prev_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    dom_d   = dom_q;
    done_d  = done_q;

    count_d = count_q;
    if (bus.hold_reset_i && !hold_prev_q && (count_q != {CNT_BITS{1'b1}}))
      count_d = count_q + 1'b1;

    if (bus.hold_reset_i) begin
      state_d = HOLD;
      stage_d = '0;
      cnt_d   = '0;
      for (int k = 0; k < NUM_DOMAINS; k++) pulse_d[k] = '0;
      dom_d   = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = STAGE;
          stage_d = '0;
          cnt_d   = '0;
          dom_d   = '1;
          done_d  = 1'b0;
        end
        STAGE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            stage_d = stage_q + 1'b1;
            for (int k = 0; k < NUM_DOMAINS; k++)
              if (int'(stage_q) == k) dom_d[k] = 1'b0;
            if (int'(stage_q) == NUM_DOMAINS - 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_d = 1'b1;
          // A request reloads the counter, so a retrigger stretches an active pulse.
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (bus.domain_reset_req_i[k])
              pulse_d[k] = PULSE_LOAD;
            else if (pulse_q[k] != '0)
              pulse_d[k] = pulse_q[k] - 1'b1;
            dom_d[k] = (pulse_d[k] != '0);
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= HOLD;
      stage_q     <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_DOMAINS; k++) pulse_q[k] <= '0;
      dom_q       <= '1;
      done_q      <= 1'b0;
      count_q     <= '0;
      // Hold is normally still high when core reset drops; that is not a new event.
      hold_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      for (int k = 0; k < NUM_DOMAINS; k++) pulse_q[k] <= pulse_d[k];
      dom_q       <= dom_d;
      done_q      <= done_d;
      count_q     <= count_d;
      hold_prev_q <= bus.hold_reset_i;
    end
  end

  assign bus.domain_reset_o     = dom_q;
  assign bus.sequence_done_o    = done_q;
  assign bus.hold_reset_count_o = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected per-edge outputs are queued as stimulus is driven, popped after each edge.
module tb_reset_sequencer;

  localparam int ND   = 4;
  localparam int STAG = 8;
  localparam int PUL  = 16;
  localparam int CB   = 4;

  typedef struct {
    logic [ND-1:0] dom;
    logic          done;
  } exp_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  exp_t q[$];

  reset_sequencer_if #(.NUM_DOMAINS(ND), .CNT_BITS(CB)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .STAGGER_CYCLES(STAG),
    .PULSE_CYCLES  (PUL),
    .CNT_BITS      (CB)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outputs at edge t0+off after hold is first sampled low at t0.
  function automatic exp_t stagger_exp(input int off);
    exp_t e;
    for (int k = 0; k < ND; k++) e.dom[k] = (off < (k + 1) * STAG);
    e.done = (off >= ND * STAG);
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.hold_reset_i = 1'b1;
    bus.domain_reset_req_i = '0;
    repeat (5) tick();
    total++;
    if (bus.domain_reset_o !== 4'b1111) begin
      bad++; $display("FAIL reset_dom got=%b exp=1111", bus.domain_reset_o);
    end
    total++;
    if (bus.sequence_done_o !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b exp=0", bus.sequence_done_o);
    end
    total++;
    if (bus.hold_reset_count_o !== 4'd0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", bus.hold_reset_count_o);
    end
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.hold_reset_count_o !== 4'd0) begin
      bad++; $display("FAIL hold_at_release_count got=%0d exp=0", bus.hold_reset_count_o);
    end
    total++;
    if (bus.domain_reset_o !== 4'b1111 || bus.sequence_done_o !== 1'b0) begin
      bad++; $display("FAIL hold_state got dom=%b done=%b exp dom=1111 done=0",
                      bus.domain_reset_o, bus.sequence_done_o);
    end
  endtask

  task automatic test_power_on();
    exp_t e;
    bus.hold_reset_i = 1'b0;
    for (int off = 0; off < 40; off++) begin
      q.push_back(stagger_exp(off));
      tick();
      e = q.pop_front();
      total++;
      if (bus.domain_reset_o !== e.dom || bus.sequence_done_o !== e.done) begin
        bad++;
        $display("FAIL power_on off=%0d got dom=%b done=%b exp dom=%b done=%b",
                 off, bus.domain_reset_o, bus.sequence_done_o, e.dom, e.done);
      end
    end
    total++;
    if (bus.hold_reset_count_o !== 4'(exp_cnt)) begin
      bad++; $display("FAIL power_on_count got=%0d exp=%0d", bus.hold_reset_count_o, exp_cnt);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    bus.hold_reset_i = 1'b1;
    tick();
    exp_cnt++;
    tick();
    bus.hold_reset_i = 1'b0;
    // Hold is sampled high at t0+21..t0+23; t1 = t0+24.
    for (int off = 0; off < 24 + 40; off++) begin
      bus.hold_reset_i = (off >= 21 && off <= 23);
      if (off == 21) exp_cnt++;
      if (off <= 20) e = stagger_exp(off);
      else if (off <= 23) begin e.dom = 4'b1111; e.done = 1'b0; end
      else e = stagger_exp(off - 24);
      q.push_back(e);
      tick();
      e = q.pop_front();
      total++;
      if (bus.domain_reset_o !== e.dom || bus.sequence_done_o !== e.done) begin
        bad++;
        $display("FAIL abort off=%0d got dom=%b done=%b exp dom=%b done=%b",
                 off, bus.domain_reset_o, bus.sequence_done_o, e.dom, e.done);
      end
    end
    bus.hold_reset_i = 1'b0;
    total++;
    if (bus.hold_reset_count_o !== 4'(exp_cnt)) begin
      bad++; $display("FAIL abort_count got=%0d exp=%0d", bus.hold_reset_count_o, exp_cnt);
    end
  endtask

  task automatic test_pulse();
    exp_t e;
    for (int off = 0; off < 20; off++) begin
      bus.domain_reset_req_i = (off == 0) ? 4'b0100 : 4'b0000;
      e.dom  = {1'b0, (off < PUL), 2'b00};
      e.done = 1'b1;
      q.push_back(e);
      tick();
      e = q.pop_front();
      total++;
      if (bus.domain_reset_o !== e.dom || bus.sequence_done_o !== e.done) begin
        bad++;
        $display("FAIL pulse off=%0d got dom=%b done=%b exp dom=%b done=%b",
                 off, bus.domain_reset_o, bus.sequence_done_o, e.dom, e.done);
      end
    end
    bus.domain_reset_req_i = '0;
  endtask

  task automatic test_retrigger();
    exp_t e;
    for (int off = 0; off < 28; off++) begin
      if (off == 0) bus.domain_reset_req_i = 4'b0001;
      else if (off == 8) bus.domain_reset_req_i = 4'b0011;
      else bus.domain_reset_req_i = 4'b0000;
      e.dom  = {2'b00, (off >= 8 && off < 24), (off < 24)};
      e.done = 1'b1;
      q.push_back(e);
      tick();
      e = q.pop_front();
      total++;
      if (bus.domain_reset_o !== e.dom || bus.sequence_done_o !== e.done) begin
        bad++;
        $display("FAIL retrigger off=%0d got dom=%b done=%b exp dom=%b done=%b",
                 off, bus.domain_reset_o, bus.sequence_done_o, e.dom, e.done);
      end
    end
    bus.domain_reset_req_i = '0;
  endtask

  task automatic test_ignored();
    exp_t e;
    bus.hold_reset_i = 1'b1;
    tick();
    exp_cnt++;
    bus.hold_reset_i = 1'b0;
    for (int off = 0; off < 50; off++) begin
      bus.domain_reset_req_i = (off == 3 || off == 12 || off == 31) ? 4'b1111 : 4'b0000;
      q.push_back(stagger_exp(off));
      tick();
      e = q.pop_front();
      total++;
      if (bus.domain_reset_o !== e.dom || bus.sequence_done_o !== e.done) begin
        bad++;
        $display("FAIL ignored_req off=%0d got dom=%b done=%b exp dom=%b done=%b",
                 off, bus.domain_reset_o, bus.sequence_done_o, e.dom, e.done);
      end
    end
    bus.domain_reset_req_i = '0;
    total++;
    if (bus.hold_reset_count_o !== 4'(exp_cnt)) begin
      bad++; $display("FAIL ignored_count got=%0d exp=%0d", bus.hold_reset_count_o, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    int cq[$];
    int c;
    for (int i = 0; i < 20; i++) begin
      bus.hold_reset_i = 1'b1;
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      cq.push_back(exp_cnt);
      tick();
      c = cq.pop_front();
      total++;
      if (bus.hold_reset_count_o !== 4'(c)) begin
        bad++; $display("FAIL saturate edge=%0d got=%0d exp=%0d", i, bus.hold_reset_count_o, c);
      end
      bus.hold_reset_i = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.hold_reset_count_o !== 4'd0) begin
      bad++; $display("FAIL count_after_reset got=%0d exp=0", bus.hold_reset_count_o);
    end
    total++;
    if (bus.domain_reset_o !== 4'b1111 || bus.sequence_done_o !== 1'b0) begin
      bad++; $display("FAIL outputs_after_reset got dom=%b done=%b exp dom=1111 done=0",
                      bus.domain_reset_o, bus.sequence_done_o);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.hold_reset_i = 1'b1;
    bus.domain_reset_req_i = '0;
    test_reset();
    test_power_on();
    test_abort();
    test_pulse();
    test_retrigger();
    test_ignored();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the startup/hold reset generator.
- Consumes the generator's long hold reset and releases the per-subsystem resets (GBT, trigger, S-bit, control) in a fixed staggered order.
- After the sequence completes, it serves per-domain stretched reset requests from control logic.
- It also counts how many times the hold reset has re-asserted, for status readout.

Parameters:
- NUM_DOMAINS, 4, number of reset domains; legal range 1..16; bit 0 is released first.
- STAGGER_CYCLES, 64, cycles between successive domain releases; must be >= 1.
- PULSE_CYCLES, 32, length in cycles of a per-domain requested reset; must be >= 1.
- CNT_BITS, 16, width of the saturating hold-reset event counter.

Ports:
- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset; connected to the core (short) reset.
- hold_reset_i  in  1  long hold reset from the reset generator; active high, synchronous to clock_i.
- domain_reset_req_i  in  NUM_DOMAINS  one-cycle request pulses, one bit per domain.
- domain_reset_o  out  NUM_DOMAINS  per-domain active-high resets, registered.
- sequence_done_o  out  1  high once all domains have been released, registered.
- hold_reset_count_o  out  CNT_BITS  saturating count of hold_reset_i rising edges.

Behaviour:
- Reset (reset_i=1, takes priority over everything):
  - state=HOLD, domain_reset_o all ones, sequence_done_o=0.
  - Stage index and stagger counter = 0; all pulse counters = 0; hold_reset_count_o=0.
  - Previous-hold register = 1, so hold already high at reset release is not counted.
- State HOLD:
  - All domain_reset_o bits = 1; sequence_done_o=0.
  - Edge that samples hold_reset_i=0 moves state to STAGE with stage=0, cnt=0.
- State STAGE:
  - cnt increments every cycle.
  - On the edge where cnt==STAGGER_CYCLES-1: clear domain_reset_o[stage], set cnt=0, increment stage.
  - If the cleared stage is NUM_DOMAINS-1, go to DONE and set sequence_done_o=1 on that same edge.
  - Timing: if hold low is first sampled at edge t0, domain k deasserts at edge t0+(k+1)*STAGGER_CYCLES.
  - Already-released domains stay low; later domains stay high.
- State DONE:
  - sequence_done_o=1.
  - domain_reset_req_i[k]=1 loads pulse_cnt[k]=PULSE_CYCLES and drives domain_reset_o[k]=1 from the next edge.
  - The counter decrements each cycle; the bit clears on the edge where it reaches 0, giving exactly PULSE_CYCLES high cycles.
  - A request while that domain's pulse is active reloads the counter (retrigger extends the pulse).
  - Simultaneous requests on several bits are handled independently.
  - sequence_done_o stays 1 during per-domain pulses.
- Requests received in HOLD or STAGE are ignored and not queued.
- hold_reset_i=1 sampled in any state:
  - Next edge: state=HOLD, all domain_reset_o=1, sequence_done_o=0.
  - Stage, cnt and all pulse counters cleared.
  - A mid-sequence re-assertion aborts and restarts the full sequence from domain 0.
- Event counter:
  - hold_reset_count_o increments by 1 on each edge where hold_reset_i=1 and the previous sample was 0.
  - Saturates at 2^CNT_BITS-1; no wrap.
  - Counting is independent of state.
- Widths:
  - Stagger counter: clog2(STAGGER_CYCLES) bits, minimum 1.
  - Pulse counters: clog2(PULSE_CYCLES+1) bits.
  - Stage index: clog2(NUM_DOMAINS) bits, minimum 1.
  - No combinational path from any input to any output.

Test Plan (NUM_DOMAINS=4, STAGGER_CYCLES=8, PULSE_CYCLES=16, CNT_BITS=4 where noted):
- Power-on sequence:
  - Stimulus: reset_i high 5 cycles with hold=1; then hold=0 at t0.
  - Required: domain_reset_o goes 1111 -> 1110 at t0+8, 1100 at t0+16, 1000 at t0+24, 0000 at t0+32.
  - Required: sequence_done_o rises at t0+32.
- Mid-sequence abort:
  - Stimulus: hold re-asserted at t0+20 (domains 0,1 released) for 3 cycles, then deasserted at t1.
  - Required: all bits back to 1 at t0+21; full sequence restarts, 0000 at t1+32.
  - Required: hold_reset_count_o increments by 1.
- Per-domain pulse:
  - Stimulus: in DONE, one-cycle domain_reset_req_i=0100.
  - Required: domain_reset_o[2] high exactly 16 cycles starting the next edge; other bits stay 0; sequence_done_o stays 1.
- Retrigger and simultaneous requests:
  - Stimulus: req=0001, then req=0011 eight cycles later.
  - Required: bit0 high 24 cycles total; bit1 high 16 cycles.
- Ignored request:
  - Stimulus: req=1111 pulsed during STAGE.
  - Required: release timing identical to the power-on case; no pulses after DONE.
- Counter saturation (CNT_BITS=4):
  - Stimulus: 20 hold rising edges.
  - Required: count stops at 15; reset_i returns it to 0.
